// File: rtl/fetch_pkg.sv
// Shared types and widths for the PC fetch unit and its fetch queue.
// IMEM_ADDR_W / IMEM_W mirror the instruction-memory widths from def.h.
package fetch_pkg;

   localparam int IMEM_ADDR_W = 8;
   localparam int IMEM_W      = 32;
   localparam int QDEPTH_DEF  = 2;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [IMEM_ADDR_W-1:0] pc;
      logic [IMEM_W-1:0]      instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} entries; flush empties it in one cycle.
// The head is read straight from storage, so it is stable until popped.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DEF,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic               flush,
   input  fetch_entry_t       push_entry,
   output logic [CW-1:0]      count,
   output fetch_entry_t       head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t        mem [DEPTH];
   logic [PW-1:0]       rd_ptr;
   logic [PW-1:0]       wr_ptr;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign head = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         // Cleared so the head reads as zero straight out of reset.
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Sequential instruction fetch into a short queue toward the decoder.
// A zero instruction word halts fetch; a redirect flushes and restarts anywhere.
module pc_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [IMEM_ADDR_W-1:0] RESET_PC = '0,
   parameter int                     QDEPTH   = QDEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [IMEM_ADDR_W-1:0] imem_addr,
   input  logic [IMEM_W-1:0]      imem_data,
   input  logic                   redirect_valid,
   input  logic [IMEM_ADDR_W-1:0] redirect_pc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [IMEM_W-1:0]      out_instr,
   output logic [IMEM_ADDR_W-1:0] out_pc,
   output logic                   halted
);

   localparam int CW = $clog2(QDEPTH + 1);

   fetch_state_t           state;
   logic [IMEM_ADDR_W-1:0] fetch_pc;
   logic [CW-1:0]          count;
   fetch_entry_t           head;
   fetch_entry_t           new_entry;
   logic                   pop;
   logic                   fetch_opp;
   logic                   push;

   assign imem_addr = fetch_pc;
   assign out_valid = (count != '0);
   assign out_pc    = head.pc;
   assign out_instr = head.instr;

   assign pop       = out_valid && out_ready;
   // A slot is available if the queue has room or its head leaves this cycle.
   assign fetch_opp = (state == RUN) && ((count < CW'(QDEPTH)) || pop);
   assign push      = !redirect_valid && fetch_opp && (imem_data != '0);

   assign new_entry.pc    = fetch_pc;
   assign new_entry.instr = imem_data;

   fetch_queue #(
      .DEPTH (QDEPTH),
      .CW    (CW)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop && !redirect_valid),
      .flush      (redirect_valid),
      .push_entry (new_entry),
      .count      (count),
      .head       (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= BOOT;
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
      end else if (redirect_valid) begin
         state    <= RUN;
         fetch_pc <= redirect_pc;
         halted   <= 1'b0;
      end else begin
         case (state)
            BOOT: state <= RUN;
            RUN: begin
               if (push) begin
                  fetch_pc <= fetch_pc + IMEM_ADDR_W'(1);
               end else if (fetch_opp) begin
                  // Zero word at a real fetch opportunity: stop, pc stays on it.
                  state  <= HALT;
                  halted <= 1'b1;
               end
            end
            HALT: state <= HALT;
            default: begin
               state  <= BOOT;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_fetch_unit;
   import fetch_pkg::*;

   localparam int AW = IMEM_ADDR_W;
   localparam int DW = IMEM_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, redirect_valid, out_ready;
   logic [AW-1:0] redirect_pc;
   logic [AW-1:0] imem_addr, out_pc, imem_addr1, out_pc1;
   logic [DW-1:0] imem_data, out_instr, imem_data1, out_instr1;
   logic          out_valid, halted, out_valid1, halted1;

   logic [DW-1:0] imem [256];
   assign imem_data  = imem[imem_addr];
   assign imem_data1 = imem[imem_addr1];

   pc_fetch_unit #(.RESET_PC(8'h00), .QDEPTH(2)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .halted(halted));

   pc_fetch_unit #(.RESET_PC(8'hFF), .QDEPTH(2)) dut1 (
      .clk(clk), .reset(reset), .imem_addr(imem_addr1), .imem_data(imem_data1),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
      .out_pc(out_pc1), .halted(halted1));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   typedef struct {
      logic [AW-1:0] pc;
      logic [DW-1:0] instr;
   } ent_t;

   // Reference model: queue contents, next fetch address, mode (0 boot, 1 run, 2 halt).
   ent_t          mq[$];
   logic [AW-1:0] mpc;
   int            mmode;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("imem_addr", imem_addr, mpc);
         chk("out_valid", out_valid, mq.size() != 0);
         chk("halted", halted, mmode == 2);
         if (mq.size() != 0) begin
            chk("out_pc", out_pc, mq[0].pc);
            chk("out_instr", out_instr, mq[0].instr);
         end
      end
   end

   // One clock: derive the model's next state from the inputs now applied.
   task automatic cyc();
      ent_t          nq[$];
      logic [AW-1:0] npc;
      int            nmode;
      nq = mq; npc = mpc; nmode = mmode;
      if (reset) begin
         nq.delete(); npc = '0; nmode = 0;
      end else if (redirect_valid) begin
         nq.delete(); npc = redirect_pc; nmode = 1;
      end else begin
         if (nq.size() > 0 && out_ready) void'(nq.pop_front());
         if (nmode == 0) nmode = 1;
         else if (nmode == 1 && nq.size() < 2) begin
            if (imem[npc] == '0) nmode = 2;
            else begin
               nq.push_back('{npc, imem[npc]});
               npc = npc + 8'd1;
            end
         end
      end
      @(posedge clk); #1;
      mq = nq; mpc = npc; mmode = nmode;
      @(negedge clk); #2;
   endtask

   initial begin
      logic [AW-1:0] seen[$];
      for (int i = 0; i < 256; i++) imem[i] = DW'(i + 100);
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      mq.delete(); mpc = '0; mmode = 0;
      @(negedge clk); #2;
      cyc(); cyc();
      chk_en = 1'b1;

      // Reset state
      chk("rst out_valid", out_valid, 0);
      chk("rst out_pc", out_pc, 0);
      chk("rst out_instr", out_instr, 0);
      chk("rst halted", halted, 0);
      chk("rst imem_addr", imem_addr, 0);
      chk("rst imem_addr1", imem_addr1, 8'hFF);

      // Streaming with ready high; second instance shows the pc wrap
      out_ready = 1'b1; reset = 1'b0;
      cyc();
      chk("boot no push", out_valid, 0);
      cyc();
      chk("first valid", out_valid, 1);
      chk("first pc", out_pc, 0);
      chk("first instr", out_instr, 100);
      chk("wrap pc0", out_pc1, 8'hFF);
      cyc();
      chk("second pc", out_pc, 1);
      chk("second instr", out_instr, 101);
      chk("wrap pc1", out_pc1, 8'h00);
      cyc();
      chk("third instr", out_instr, 102);
      chk("wrap pc2", out_pc1, 8'h01);

      // Backpressure: queue fills, fetch stalls, release drains in order
      reset = 1'b1; out_ready = 1'b0; cyc();
      reset = 1'b0;
      repeat (5) cyc();
      chk("stall imem_addr", imem_addr, 2);
      chk("stall head", out_pc, 0);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("release order", out_pc, k);
         cyc();
      end

      // Redirect with two entries queued
      out_ready = 1'b0; cyc();
      redirect_valid = 1'b1; redirect_pc = 8'd9; out_ready = 1'b1; cyc();
      redirect_valid = 1'b0;
      chk("redir flush", out_valid, 0);
      chk("redir addr", imem_addr, 9);
      cyc();
      chk("redir pc", out_pc, 9);
      chk("redir instr", out_instr, 109);

      // Zero word at address 5 halts fetch
      imem[5] = '0;
      reset = 1'b1; cyc();
      reset = 1'b0;
      repeat (14) begin
         cyc();
         if (out_valid) seen.push_back(out_pc);
      end
      chk("halt count", seen.size(), 5);
      for (int i = 0; i < seen.size() && i < 5; i++) chk("halt seq", seen[i], i);
      chk("halted", halted, 1);
      redirect_valid = 1'b1; redirect_pc = 8'd0; cyc();
      redirect_valid = 1'b0;
      chk("unhalt", halted, 0);
      cyc();
      chk("resume pc", out_pc, 0);
      imem[5] = DW'(105);

      // Reset beats a coincident redirect with a full queue
      out_ready = 1'b0;
      repeat (3) cyc();
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'd33; cyc();
      reset = 1'b0; redirect_valid = 1'b0;
      chk("rst+redir valid", out_valid, 0);
      chk("rst+redir addr", imem_addr, 0);
      out_ready = 1'b1; cyc();
      chk("rst+redir boot", out_valid, 0);
      cyc();
      chk("rst+redir run", out_pc, 0);

      // Randomized traffic with sparse zero words
      for (int i = 0; i < 256; i++)
         imem[i] = ($urandom_range(0, 19) == 0) ? '0 : ($urandom() | 32'h1);
      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 99) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = AW'($urandom());
         out_ready      = ($urandom_range(0, 3) != 0);
         cyc();
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
